// File: rtl/hci_core_cmd_queue_tagged_pkg.sv
//------------------------------------------------------------------------------
// hci_package
// Shared types and defaults for the tagged HCI streamer command queue.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package hci_package;

  typedef enum logic {HCI_CMDQ_IDLE, HCI_CMDQ_BUSY} hci_cmdq_state_e;

  localparam int HCI_CMDQ_DEFAULT_WIDTH = 226;

  // A single-entry FIFO still needs a one-bit pointer to stay legal.
  function automatic int hci_ptr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/hci_core_cmd_fifo.sv
//------------------------------------------------------------------------------
// hci_core_cmd_fifo
// Fall-through FIFO of arbitrary depth with synchronous flush and occupancy count.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module hci_core_cmd_fifo
  import hci_package::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       clear_i,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           data_i,
  input  logic                       pop_i,
  output logic [WIDTH-1:0]           data_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);

  localparam int PTR_W = hci_ptr_width(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);
  localparam logic [PTR_W-1:0] c_last  = PTR_W'(DEPTH-1);
  localparam logic [CNT_W-1:0] c_depth = CNT_W'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_push;
  logic             w_pop;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] ptr);
    return (ptr == c_last) ? '0 : ptr + 1'b1;
  endfunction

  assign full_o  = (r_count == c_depth);
  assign empty_o = (r_count == '0);
  assign count_o = r_count;
  assign data_o  = r_mem[r_rd_ptr];
  assign w_push  = push_i & ~full_o;
  assign w_pop   = pop_i & ~empty_o;

  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= next_ptr(r_wr_ptr);
      if (w_pop)  r_rd_ptr <= next_ptr(r_rd_ptr);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage needs no reset; occupancy alone defines which words are valid.
  always_ff @(posedge clk_i) begin
    if (w_push) r_mem[r_wr_ptr] <= data_i;
  end

endmodule

`default_nettype wire

// File: rtl/hci_core_cmd_queue_tagged.sv
//------------------------------------------------------------------------------
// hci_core_cmd_queue_tagged
// Tagged command queue issuing one command at a time to an HCI streamer.
// Optional zero-latency bypass: define HCI_CMD_QUEUE_BYPASS_EN.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module hci_core_cmd_queue_tagged
  import hci_package::*;
#(
  parameter int CMD_WIDTH = HCI_CMDQ_DEFAULT_WIDTH,
  parameter int DEPTH     = 2,
  parameter int TAG_WIDTH = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       clear_i,
  input  logic                       enable_i,
  input  logic [CMD_WIDTH-1:0]       cmd_data_i,
  input  logic                       cmd_valid_i,
  output logic                       cmd_ready_o,
  output logic [TAG_WIDTH-1:0]       cmd_tag_o,
  output logic                       req_start_o,
  output logic [CMD_WIDTH-1:0]       ctrl_o,
  input  logic                       ready_start_i,
  input  logic                       done_i,
  output logic                       done_o,
  output logic [TAG_WIDTH-1:0]       done_tag_o,
  output logic                       busy_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);

  localparam int ENTRY_W = CMD_WIDTH + TAG_WIDTH;

  hci_cmdq_state_e        r_state;
  hci_cmdq_state_e        w_state_next;
  logic [CMD_WIDTH-1:0]   r_ctrl_q;
  logic [TAG_WIDTH-1:0]   r_tag_q;
  logic [TAG_WIDTH-1:0]   r_tag_cnt;
  logic                   r_done;
  logic [TAG_WIDTH-1:0]   r_done_tag;

  logic                   w_fifo_full;
  logic                   w_fifo_empty;
  logic [ENTRY_W-1:0]     w_head;
  logic                   w_push_acc;
  logic                   w_bypass;
  logic                   w_req_queue;
  logic                   w_issue;
  logic                   w_issue_bypass;
  logic                   w_fifo_push;
  logic                   w_fifo_pop;

  assign w_push_acc = cmd_valid_i & ~w_fifo_full & ~clear_i;

`ifdef HCI_CMD_QUEUE_BYPASS_EN
  assign w_bypass = (r_state == HCI_CMDQ_IDLE) & w_fifo_empty & enable_i
                  & cmd_valid_i & ~clear_i;
`else
  assign w_bypass = 1'b0;
`endif

  assign w_req_queue    = (r_state == HCI_CMDQ_IDLE) & enable_i & ~w_fifo_empty;
  assign w_issue        = req_start_o & ready_start_i;
  assign w_issue_bypass = w_bypass & ready_start_i;
  assign w_fifo_push    = w_push_acc & ~w_issue_bypass;
  assign w_fifo_pop     = w_req_queue & ready_start_i;

  hci_core_cmd_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .clear_i (clear_i),
    .push_i  (w_fifo_push),
    .data_i  ({cmd_data_i, r_tag_cnt}),
    .pop_i   (w_fifo_pop),
    .data_o  (w_head),
    .full_o  (w_fifo_full),
    .empty_o (w_fifo_empty),
    .count_o (count_o)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) r_state <= HCI_CMDQ_IDLE;
    else       r_state <= w_state_next;
  end

  // BUSY is held through the done_o cycle so re-issue starts one cycle later.
  always_comb begin
    w_state_next = r_state;
    req_start_o  = 1'b0;
    ctrl_o       = '0;
    case (r_state)
      HCI_CMDQ_IDLE: begin
        req_start_o = w_req_queue | w_bypass;
        if (w_bypass)           ctrl_o = cmd_data_i;
        else if (!w_fifo_empty) ctrl_o = w_head[ENTRY_W-1:TAG_WIDTH];
        if (w_issue) w_state_next = HCI_CMDQ_BUSY;
      end
      HCI_CMDQ_BUSY: begin
        ctrl_o = r_ctrl_q;
        if (r_done) w_state_next = HCI_CMDQ_IDLE;
      end
      default: w_state_next = HCI_CMDQ_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_ctrl_q   <= '0;
      r_tag_q    <= '0;
      r_tag_cnt  <= '0;
      r_done     <= 1'b0;
      r_done_tag <= '0;
    end else begin
      if (w_push_acc) r_tag_cnt <= r_tag_cnt + 1'b1;
      if (w_issue_bypass) begin
        r_ctrl_q <= cmd_data_i;
        r_tag_q  <= r_tag_cnt;
      end else if (w_fifo_pop) begin
        r_ctrl_q <= w_head[ENTRY_W-1:TAG_WIDTH];
        r_tag_q  <= w_head[TAG_WIDTH-1:0];
      end
      r_done <= (r_state == HCI_CMDQ_BUSY) & ~r_done & done_i;
      if ((r_state == HCI_CMDQ_BUSY) && !r_done && done_i) r_done_tag <= r_tag_q;
    end
  end

  assign cmd_ready_o = ~w_fifo_full;
  assign cmd_tag_o   = r_tag_cnt;
  assign done_o      = r_done;
  assign done_tag_o  = r_done_tag;
  assign busy_o      = (r_state == HCI_CMDQ_BUSY) | ~w_fifo_empty;

endmodule

`default_nettype wire

// File: tb/tb_hci_core_cmd_queue_tagged.sv
//------------------------------------------------------------------------------
// tb_hci_core_cmd_queue_tagged
// Scoreboard bench: queue-level reference model, decoupled issue/done monitor.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_hci_core_cmd_queue_tagged;

  localparam int CW = 40;
  localparam int D  = 2;
  localparam int TW = 2;
  localparam int CNTW = $clog2(D+1);

  typedef struct packed {
    logic [CW-1:0] d;
    logic [TW-1:0] t;
  } entry_t;

  logic            clk = 1'b0;
  logic            rst_i, clear_i, enable_i, cmd_valid_i, ready_start_i, done_i;
  logic [CW-1:0]   cmd_data_i;
  logic            cmd_ready_o, req_start_o, done_o, busy_o;
  logic [TW-1:0]   cmd_tag_o, done_tag_o;
  logic [CW-1:0]   ctrl_o;
  logic [CNTW-1:0] count_o;

  hci_core_cmd_queue_tagged #(.CMD_WIDTH(CW), .DEPTH(D), .TAG_WIDTH(TW)) dut (
    .clk_i(clk), .rst_i(rst_i), .clear_i(clear_i), .enable_i(enable_i),
    .cmd_data_i(cmd_data_i), .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o),
    .cmd_tag_o(cmd_tag_o), .req_start_o(req_start_o), .ctrl_o(ctrl_o),
    .ready_start_i(ready_start_i), .done_i(done_i), .done_o(done_o),
    .done_tag_o(done_tag_o), .busy_o(busy_o), .count_o(count_o)
  );

  always #5 clk = ~clk;

  int nvec = 0;
  int nerr = 0;
  bit sb_on = 0;

  // Reference model: queue contents, in-flight command, pending done report
  entry_t        mq[$];
  entry_t        iq[$];
  logic [TW-1:0] dq[$];
  bit            inflight = 0;
  bit            donepend = 0;
  logic [TW-1:0] inflight_tag = '0;
  logic [TW-1:0] tagc = '0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Scoreboard: checks status outputs and predicts the effect of the next edge
  always @(negedge clk) begin
    if (sb_on) begin
      int  sz;
      bit  exp_req, issue, push_ok;
      entry_t e;
      sz      = mq.size();
      exp_req = enable_i && !inflight && !donepend && (sz > 0);
      chk("count_o", 64'(count_o), 64'(sz));
      chk("cmd_ready_o", 64'(cmd_ready_o), 64'(sz < D));
      chk("busy_o", 64'(busy_o), 64'(inflight || donepend || sz > 0));
      chk("req_start_o", 64'(req_start_o), 64'(exp_req));
      chk("done_o", 64'(done_o), 64'(donepend));
      chk("cmd_tag_o", 64'(cmd_tag_o), 64'(tagc));
      if (rst_i) begin
        mq.delete();
        inflight = 0;
        donepend = 0;
        tagc     = '0;
      end else begin
        issue   = exp_req && ready_start_i;
        push_ok = cmd_valid_i && (sz < D) && !clear_i;
        donepend = 0;
        if (inflight && done_i) begin
          dq.push_back(inflight_tag);
          inflight = 0;
          donepend = 1;
        end
        if (issue) begin
          e = mq.pop_front();
          iq.push_back(e);
          inflight     = 1;
          inflight_tag = e.t;
        end
        if (clear_i) mq.delete();
        else if (push_ok) begin
          e.d = cmd_data_i;
          e.t = tagc;
          mq.push_back(e);
          tagc = tagc + 1'b1;
        end
      end
    end
  end

  // Monitor: consumes expectations whenever the DUT presents an issue or a completion
  always @(negedge clk) begin
    if (sb_on) begin
      entry_t e;
      #1;
      if (req_start_o && ready_start_i && !rst_i) begin
        if (iq.size() == 0) chk("unexpected_issue", 64'(1), 64'(0));
        else begin
          e = iq.pop_front();
          chk("issue_ctrl_o", 64'(ctrl_o), 64'(e.d));
        end
      end
      if (done_o) begin
        if (dq.size() == 0) chk("unexpected_done", 64'(1), 64'(0));
        else chk("done_tag_o", 64'(done_tag_o), 64'(dq.pop_front()));
      end
    end
  end

  task automatic cyc(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push(input logic [CW-1:0] d);
    cmd_valid_i = 1'b1;
    cmd_data_i  = d;
    cyc();
    cmd_valid_i = 1'b0;
  endtask

  task automatic pulse_done();
    done_i = 1'b1;
    cyc();
    done_i = 1'b0;
  endtask

  initial begin
    int budget;
    rst_i = 1'b1; clear_i = 1'b0; enable_i = 1'b1; cmd_valid_i = 1'b0;
    ready_start_i = 1'b0; done_i = 1'b0; cmd_data_i = '0;
    cyc(2);
    sb_on = 1;
    @(negedge clk);
    chk("reset_ctrl_o", 64'(ctrl_o), 64'(0));
    chk("reset_done_tag_o", 64'(done_tag_o), 64'(0));
    cyc();
    rst_i = 1'b0;
    cyc();

    // single command, start accepted immediately
    ready_start_i = 1'b1;
    push(40'hA0A0A0A0A0);
    cyc(2);
    pulse_done();
    cyc(3);

    // fill with start refused, third push refused, then drain
    ready_start_i = 1'b0;
    push(40'h1111111111);
    push(40'h2222222222);
    push(40'h3333333333);
    ready_start_i = 1'b1;
    for (int i = 0; i < 2; i++) begin
      cyc(2);
      pulse_done();
      cyc();
    end
    cyc(2);

    // done_i while idle is ignored
    pulse_done();
    cyc();

    // clear while two queued and one in flight
    push(40'h4444444444);
    cyc();
    ready_start_i = 1'b0;
    push(40'h5555555555);
    push(40'h6666666666);
    clear_i = 1'b1;
    cyc();
    clear_i = 1'b0;
    cyc();
    pulse_done();
    cyc(3);

    // enable low holds a queued command
    ready_start_i = 1'b1;
    enable_i = 1'b0;
    push(40'h7777777777);
    cyc(10);
    enable_i = 1'b1;
    cyc(2);
    pulse_done();
    cyc(2);

    // reset while busy, later done_i ignored
    push(40'h8888888888);
    cyc(2);
    rst_i = 1'b1;
    cyc();
    rst_i = 1'b0;
    pulse_done();
    cyc(2);

    // randomized traffic
    for (int i = 0; i < 800; i++) begin
      cmd_valid_i   = ($urandom_range(0, 99) < 50);
      cmd_data_i    = {8'($urandom), 32'($urandom)};
      enable_i      = ($urandom_range(0, 99) < 85);
      ready_start_i = ($urandom_range(0, 99) < 60);
      done_i        = ($urandom_range(0, 99) < 30);
      clear_i       = ($urandom_range(0, 99) < 3);
      cyc();
    end

    // drain, bounded
    cmd_valid_i = 1'b0; clear_i = 1'b0; enable_i = 1'b1; ready_start_i = 1'b1;
    budget = 0;
    while ((mq.size() != 0 || inflight || donepend) && budget < 200) begin
      done_i = ($urandom_range(0, 1) == 1);
      cyc();
      budget++;
    end
    done_i = 1'b0;
    chk("drain_timeout", 64'(budget >= 200), 64'(0));
    cyc(3);
    chk("leftover_issues", 64'(iq.size()), 64'(0));
    chk("leftover_dones", 64'(dq.size()), 64'(0));
    sb_on = 0;
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

`default_nettype wire
